// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lcd_pkg
// Brief    : Shared types, timing defaults and HD44780 bit positions for the
//            LCD read-direction engine.
// Revision : 1.0 - initial release
// ============================================================================
package lcd_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        EN_HI   = 3'd2,
        HOLD    = 3'd3,
        RECOVER = 3'd4
    } state_t;

    // Defaults sized for a 50 MHz clock.
    localparam int unsigned c_SETUP_CYC   = 8;
    localparam int unsigned c_EN_HIGH_CYC = 25;
    localparam int unsigned c_SAMPLE_CYC  = 20;
    localparam int unsigned c_HOLD_CYC    = 2;
    localparam int unsigned c_RECOVER_CYC = 25;
    localparam int unsigned c_POLL_MAX    = 2000;

    localparam int unsigned c_BF_BIT = 7;
    localparam int unsigned c_AC_MSB = 6;

    // Bits needed to hold 0..v-1, never less than one.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage : lcd_pkg
`default_nettype wire

// File: rtl/lcd_cycle_timer.sv
`default_nettype none
// ============================================================================
// Module   : lcd_cycle_timer
// Brief    : Loadable down-counter with a zero flag; times one bus phase.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_cycle_timer #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] count_o,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Loading N-1 on phase entry makes the phase last exactly N cycles.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule : lcd_cycle_timer
`default_nettype wire

// File: rtl/lcd_bus_reader.sv
`default_nettype none
// ============================================================================
// Module   : lcd_bus_reader
// Brief    : HD44780 read-cycle engine: single BF/AC or data reads, plus an
//            optional busy-flag poll with a bounded number of attempts.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_bus_reader
    import lcd_pkg::*;
#(
    parameter int unsigned SETUP_CYC   = c_SETUP_CYC,
    parameter int unsigned EN_HIGH_CYC = c_EN_HIGH_CYC,
    parameter int unsigned SAMPLE_CYC  = c_SAMPLE_CYC,
    parameter int unsigned HOLD_CYC    = c_HOLD_CYC,
    parameter int unsigned RECOVER_CYC = c_RECOVER_CYC,
    parameter int unsigned POLL_MAX    = c_POLL_MAX
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iStart,
    input  logic       iRS,
    input  logic       iPoll,
    output logic [7:0] oDATA,
    output logic       oBF,
    output logic [6:0] oAC,
    output logic       oDone,
    output logic       oBusy,
    output logic       oTimeout,
    input  logic [7:0] LCD_DATA,
    output logic       oLCD_DATA_OE,
    output logic       LCD_EN,
    output logic       LCD_RS,
    output logic       LCD_RW
);

    localparam int unsigned c_MAX_PHASE =
        max2(max2(SETUP_CYC, EN_HIGH_CYC), max2(HOLD_CYC, RECOVER_CYC));
    localparam int unsigned c_CNT_W  = clog2_min1(c_MAX_PHASE);
    localparam int unsigned c_POLL_W = clog2_min1(POLL_MAX);

    localparam logic [c_CNT_W-1:0] c_LD_SETUP   = c_CNT_W'(SETUP_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_LD_EN_HI   = c_CNT_W'(EN_HIGH_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_LD_HOLD    = c_CNT_W'(HOLD_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_LD_RECOVER = c_CNT_W'(RECOVER_CYC - 1);
    // Down-counter value that corresponds to EN-high cycle SAMPLE_CYC-1.
    localparam logic [c_CNT_W-1:0] c_SAMPLE_AT  = c_CNT_W'(EN_HIGH_CYC - SAMPLE_CYC);
    localparam logic [c_POLL_W-1:0] c_POLL_LAST = c_POLL_W'(POLL_MAX - 1);

    state_t              state_q;
    logic                rs_q;
    logic                poll_q;
    logic [c_POLL_W-1:0] poll_cnt_q;
    logic [7:0]          data_q;
    logic                bf_q;
    logic [6:0]          ac_q;
    logic                done_q;
    logic                timeout_q;
    logic                en_q;

    logic                timer_load_d;
    logic [c_CNT_W-1:0]  timer_val_d;
    logic [c_CNT_W-1:0]  timer_count;
    logic                timer_zero;
    logic                start_ok;
    logic                poll_again;

    // A request arriving on the oDone cycle is held off by one cycle.
    assign start_ok   = iStart && !done_q;
    assign poll_again = poll_q && bf_q && (poll_cnt_q != c_POLL_LAST);

    always_comb begin
        timer_load_d = 1'b0;
        timer_val_d  = c_LD_SETUP;
        unique case (state_q)
            IDLE: begin
                if (start_ok) begin
                    timer_load_d = 1'b1;
                    timer_val_d  = c_LD_SETUP;
                end
            end
            SETUP: begin
                if (timer_zero) begin
                    timer_load_d = 1'b1;
                    timer_val_d  = c_LD_EN_HI;
                end
            end
            EN_HI: begin
                if (timer_zero) begin
                    timer_load_d = 1'b1;
                    timer_val_d  = c_LD_HOLD;
                end
            end
            HOLD: begin
                if (timer_zero) begin
                    timer_load_d = 1'b1;
                    timer_val_d  = c_LD_RECOVER;
                end
            end
            RECOVER: begin
                if (timer_zero && poll_again) begin
                    timer_load_d = 1'b1;
                    timer_val_d  = c_LD_SETUP;
                end
            end
            default: begin
                timer_load_d = 1'b0;
            end
        endcase
    end

    lcd_cycle_timer #(
        .WIDTH      (c_CNT_W)
    ) u_phase_timer (
        .clk_i      (iCLK),
        .rst_i      (iRST),
        .load_i     (timer_load_d),
        .load_val_i (timer_val_d),
        .count_o    (timer_count),
        .zero_o     (timer_zero)
    );

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q    <= IDLE;
            rs_q       <= 1'b0;
            poll_q     <= 1'b0;
            poll_cnt_q <= '0;
            data_q     <= 8'h00;
            bf_q       <= 1'b0;
            ac_q       <= 7'h00;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            en_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        rs_q       <= iRS;
                        poll_q     <= iPoll & ~iRS;
                        poll_cnt_q <= '0;
                        timeout_q  <= 1'b0;
                        state_q    <= SETUP;
                    end
                end
                SETUP: begin
                    if (timer_zero) begin
                        en_q    <= 1'b1;
                        state_q <= EN_HI;
                    end
                end
                EN_HI: begin
                    if (timer_count == c_SAMPLE_AT) begin
                        data_q <= LCD_DATA;
                        if (!rs_q) begin
                            bf_q <= LCD_DATA[c_BF_BIT];
                            ac_q <= LCD_DATA[c_AC_MSB:0];
                        end
                    end
                    if (timer_zero) begin
                        en_q    <= 1'b0;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (timer_zero) begin
                        state_q <= RECOVER;
                    end
                end
                RECOVER: begin
                    if (timer_zero) begin
                        if (poll_again) begin
                            poll_cnt_q <= poll_cnt_q + c_POLL_W'(1);
                            state_q    <= SETUP;
                        end else begin
                            // Still busy here only when the attempt limit was reached.
                            done_q    <= 1'b1;
                            timeout_q <= poll_q && bf_q;
                            state_q   <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign oDATA        = data_q;
    assign oBF          = bf_q;
    assign oAC          = ac_q;
    assign oDone        = done_q;
    assign oBusy        = (state_q != IDLE);
    assign oTimeout     = timeout_q;
    assign oLCD_DATA_OE = 1'b0;
    assign LCD_EN       = en_q;
    assign LCD_RS       = rs_q;
    assign LCD_RW       = 1'b1;

endmodule : lcd_bus_reader
`default_nettype wire

// File: tb/tb_lcd_bus_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_bus_reader
// Brief    : Randomised self-checking bench for lcd_bus_reader with an LCD
//            response model and a transaction-level reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_bus_reader;

    localparam int c_POLL_MAX = 4;
    localparam int c_READ_CYC = 8 + 25 + 2 + 25;

    logic       iCLK = 1'b0;
    logic       iRST;
    logic       iStart;
    logic       iRS;
    logic       iPoll;
    logic [7:0] LCD_DATA;
    logic [7:0] oDATA;
    logic       oBF;
    logic [6:0] oAC;
    logic       oDone;
    logic       oBusy;
    logic       oTimeout;
    logic       oLCD_DATA_OE;
    logic       LCD_EN;
    logic       LCD_RS;
    logic       LCD_RW;

    always #10 iCLK = ~iCLK;

    lcd_bus_reader #(
        .POLL_MAX     (c_POLL_MAX)
    ) dut (
        .iCLK         (iCLK),
        .iRST         (iRST),
        .iStart       (iStart),
        .iRS          (iRS),
        .iPoll        (iPoll),
        .oDATA        (oDATA),
        .oBF          (oBF),
        .oAC          (oAC),
        .oDone        (oDone),
        .oBusy        (oBusy),
        .oTimeout     (oTimeout),
        .LCD_DATA     (LCD_DATA),
        .oLCD_DATA_OE (oLCD_DATA_OE),
        .LCD_EN       (LCD_EN),
        .LCD_RS       (LCD_RS),
        .LCD_RW       (LCD_RW)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // LCD side: each EN rise presents the next queued byte.
    logic [7:0] lcd_q[$];
    int         en_pulses = 0;

    always @(posedge LCD_EN) begin
        en_pulses++;
        if (lcd_q.size() > 0) LCD_DATA = lcd_q.pop_front();
        else                  LCD_DATA = 8'($urandom);
    end

    logic prev_en   = 1'b0;
    logic prev_rs   = 1'b0;
    int   en_run    = 0;
    bit   mon_width = 1'b1;

    always @(negedge iCLK) begin
        chk("oe_low", 32'(oLCD_DATA_OE), 0);
        chk("rw_high", 32'(LCD_RW), 1);
        if (!iRST && (LCD_EN || prev_en)) chk("rs_stable_en", 32'(LCD_RS), 32'(prev_rs));
        if (LCD_EN) begin
            en_run++;
        end else begin
            if (prev_en && mon_width) chk("en_width", en_run, 25);
            en_run = 0;
        end
        prev_en = LCD_EN;
        prev_rs = LCD_RS;
    end

    logic [7:0] exp_data = 8'h00;
    logic       exp_bf   = 1'b0;
    logic [6:0] exp_ac   = 7'h00;

    task automatic check_regs(input string tag);
        chk({tag, "_data"}, 32'(oDATA), 32'(exp_data));
        chk({tag, "_bf"},   32'(oBF),   32'(exp_bf));
        chk({tag, "_ac"},   32'(oAC),   32'(exp_ac));
    endtask

    // Caller is at a negedge with lcd_q holding enough bytes for the request.
    task automatic do_txn(input logic rs, input logic pl, input bit collide);
        logic [7:0] seq[$];
        logic [7:0] b;
        int  n, cyc, first_en, en0;
        bit  to, got;
        seq = lcd_q;
        n = 0; to = 1'b0; b = 8'h00;
        for (int i = 0; i < c_POLL_MAX; i++) begin
            b = seq[i];
            n = i + 1;
            if (!(pl && !rs) || !b[7]) break;
            if (n == c_POLL_MAX) to = 1'b1;
        end
        en0 = en_pulses;
        iStart = 1'b1; iRS = rs; iPoll = pl;
        @(negedge iCLK);
        if (!collide) iStart = 1'b0;
        chk("busy_on_accept", 32'(oBusy), 1);
        chk("timeout_cleared", 32'(oTimeout), 0);
        cyc = 1; first_en = 0; got = 1'b0;
        while (cyc < n * c_READ_CYC + 10) begin
            if (LCD_EN && first_en == 0) begin
                first_en = cyc;
                chk("rs_at_en", 32'(LCD_RS), 32'(rs));
            end
            if (oDone) begin
                got = 1'b1;
                break;
            end
            @(negedge iCLK);
            cyc++;
        end
        chk("done_seen", 32'(got), 1);
        if (got) begin
            chk("latency", cyc - 1, n * c_READ_CYC);
            chk("setup_len", first_en - 1, 8);
            chk("en_pulses", en_pulses - en0, n);
            chk("timeout", 32'(oTimeout), 32'(to));
            exp_data = b;
            if (!rs) begin
                exp_bf = b[7];
                exp_ac = b[6:0];
            end
            check_regs("txn");
            @(negedge iCLK);
            chk("done_one_cycle", 32'(oDone), 0);
            if (collide) begin
                chk("start_on_done_ignored", 32'(oBusy), 0);
                @(negedge iCLK);
                chk("start_after_done", 32'(oBusy), 1);
                iStart = 1'b0;
                got = 1'b0;
                for (int k = 0; k < c_READ_CYC + 10; k++) begin
                    @(negedge iCLK);
                    if (oDone) begin
                        got = 1'b1;
                        break;
                    end
                end
                chk("second_done_seen", 32'(got), 1);
                if (rs) exp_data = seq[n];
                check_regs("second");
                @(negedge iCLK);
            end
        end
        iStart = 1'b0;
        lcd_q.delete();
    endtask

    initial begin
        #1_200_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic rs_r, pl_r;
        logic [7:0] v;
        int busy_n;
        bit done_after;

        iRST = 1'b1; iStart = 1'b0; iRS = 1'b0; iPoll = 1'b0; LCD_DATA = 8'h00;
        repeat (3) @(negedge iCLK);
        chk("rst_en", 32'(LCD_EN), 0);
        chk("rst_rs", 32'(LCD_RS), 0);
        chk("rst_busy", 32'(oBusy), 0);
        chk("rst_done", 32'(oDone), 0);
        chk("rst_timeout", 32'(oTimeout), 0);
        check_regs("rst");
        iRST = 1'b0;
        @(negedge iCLK);

        lcd_q.push_back(8'h85);
        do_txn(1'b0, 1'b0, 1'b0);
        lcd_q.push_back(8'h41);
        do_txn(1'b1, 1'b0, 1'b0);
        lcd_q.push_back(8'h80); lcd_q.push_back(8'h80);
        lcd_q.push_back(8'h80); lcd_q.push_back(8'h12);
        do_txn(1'b0, 1'b1, 1'b0);
        lcd_q.push_back(8'hFF); lcd_q.push_back(8'h80);
        lcd_q.push_back(8'hC3); lcd_q.push_back(8'h9A);
        do_txn(1'b0, 1'b1, 1'b0);
        lcd_q.push_back(8'h07);
        do_txn(1'b0, 1'b0, 1'b0);
        lcd_q.push_back(8'h5A); lcd_q.push_back(8'hA5);
        do_txn(1'b1, 1'b0, 1'b1);

        for (int t = 0; t < 12; t++) begin
            rs_r   = 1'($urandom_range(0, 1));
            pl_r   = 1'($urandom_range(0, 1));
            busy_n = $urandom_range(0, 5);
            for (int i = 0; i < c_POLL_MAX; i++) begin
                v    = 8'($urandom);
                v[7] = (i < busy_n);
                lcd_q.push_back(v);
            end
            repeat ($urandom_range(0, 3)) @(negedge iCLK);
            do_txn(rs_r, pl_r, 1'b0);
        end

        // Abort a BF read while EN is high.
        lcd_q.push_back(8'h9C);
        mon_width = 1'b0;
        iStart = 1'b1; iRS = 1'b0; iPoll = 1'b0;
        @(negedge iCLK);
        iStart = 1'b0;
        for (int k = 0; k < 20 && !LCD_EN; k++) @(negedge iCLK);
        chk("en_before_rst", 32'(LCD_EN), 1);
        repeat (3) @(negedge iCLK);
        iRST = 1'b1;
        @(negedge iCLK);
        exp_data = 8'h00; exp_bf = 1'b0; exp_ac = 7'h00;
        chk("midrst_en", 32'(LCD_EN), 0);
        chk("midrst_busy", 32'(oBusy), 0);
        chk("midrst_done", 32'(oDone), 0);
        check_regs("midrst");
        iRST = 1'b0;
        done_after = 1'b0;
        repeat (80) begin
            @(negedge iCLK);
            if (oDone) done_after = 1'b1;
        end
        chk("no_done_after_rst", 32'(done_after), 0);
        chk("idle_after_rst", 32'(oBusy), 0);
        lcd_q.delete();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_lcd_bus_reader
`default_nettype wire
